// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants, widths and FSM state type for the NTT PE2 controller
package ntt_pkg;

    localparam int N          = 256;
    localparam int LOGN       = 8;
    localparam int NUM_STAGES = 7;
    localparam int Q          = 3329;
    localparam int DATA_W     = 12;

    localparam int ADDR_W  = LOGN;
    localparam int TW_W    = LOGN - 1;
    localparam int K_W     = LOGN - 1;
    localparam int STAGE_W = $clog2(LOGN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } ntt_state_e;

endpackage

// File: rtl/ntt_wb_delay.sv
// rtl/ntt_wb_delay.sv - D-deep shift register carrying {valid, addr_u, addr_v}
// from the read port to the write-back port.
module ntt_wb_delay #(
    parameter int D  = 5,
    parameter int AW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    input  logic [AW-1:0] i_addr_u,
    input  logic [AW-1:0] i_addr_v,
    output logic          o_valid,
    output logic [AW-1:0] o_addr_u,
    output logic [AW-1:0] o_addr_v
);

    logic [D-1:0]  r_valid;
    logic [AW-1:0] r_addr_u [D];
    logic [AW-1:0] r_addr_v [D];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
            for (int i = 0; i < D; i++) begin
                r_addr_u[i] <= '0;
                r_addr_v[i] <= '0;
            end
        end else begin
            r_valid[0]  <= i_valid;
            r_addr_u[0] <= i_addr_u;
            r_addr_v[0] <= i_addr_v;
            for (int i = 1; i < D; i++) begin
                r_valid[i]  <= r_valid[i-1];
                r_addr_u[i] <= r_addr_u[i-1];
                r_addr_v[i] <= r_addr_v[i-1];
            end
        end
    end

    assign o_valid  = r_valid[D-1];
    assign o_addr_u = r_addr_u[D-1];
    assign o_addr_v = r_addr_v[D-1];

endmodule

// File: rtl/ntt_pe2_ctrl.sv
// rtl/ntt_pe2_ctrl.sv - sequences one PE2 butterfly through an in-place forward NTT,
// issuing u/v/twiddle reads and the latency-matched write-back strobes.
module ntt_pe2_ctrl
    import ntt_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int PE_LAT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    output logic [STAGE_W-1:0] o_stage,
    output logic               o_rd_en,
    output logic [ADDR_W-1:0]  o_rd_addr_u,
    output logic [ADDR_W-1:0]  o_rd_addr_v,
    output logic [TW_W-1:0]    o_tw_addr,
    output logic               o_wr_en,
    output logic [ADDR_W-1:0]  o_wr_addr_lower,
    output logic [ADDR_W-1:0]  o_wr_addr_upper
);

    localparam int D      = RD_LAT + PE_LAT;
    localparam int DCNT_W = $clog2(D + 1);

    ntt_state_e         r_state, w_state_nxt;
    logic [K_W-1:0]     r_k, w_k_nxt;
    logic [STAGE_W-1:0] r_stage, w_stage_nxt;
    logic [DCNT_W-1:0]  r_dcnt, w_dcnt_nxt;

    logic               w_issue;
    logic [STAGE_W-1:0] w_shift;
    logic [ADDR_W-1:0]  w_kx;
    logic [ADDR_W-1:0]  w_h;
    logic [ADDR_W-1:0]  w_grp;
    logic [ADDR_W-1:0]  w_j;
    logic [ADDR_W-1:0]  w_u;
    logic [ADDR_W-1:0]  w_v;
    logic [TW_W-1:0]    w_tw;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_stage <= '0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_stage <= w_stage_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_stage_nxt = r_stage;
        w_dcnt_nxt  = r_dcnt;
        case (r_state)
            S_IDLE: begin
                w_k_nxt     = '0;
                w_stage_nxt = '0;
                w_dcnt_nxt  = '0;
                if (i_start) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_k_nxt = r_k + 1'b1;
                if (r_k == K_W'(N/2 - 1)) begin
                    w_state_nxt = S_DRAIN;
                    w_k_nxt     = '0;
                    w_dcnt_nxt  = '0;
                end
            end
            S_DRAIN: begin
                w_dcnt_nxt = r_dcnt + 1'b1;
                // Last write of the stage lands in this cycle, so the next read is hazard-free.
                if (r_dcnt == DCNT_W'(D - 1)) begin
                    w_dcnt_nxt = '0;
                    if (r_stage == STAGE_W'(NUM_STAGES - 1)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ISSUE;
                        w_stage_nxt = r_stage + 1'b1;
                        w_k_nxt     = '0;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_stage_nxt = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Butterfly span h = 2^shift; group index selects the block and the twiddle.
    always_comb begin
        w_shift = STAGE_W'(LOGN - 1) - r_stage;
        w_kx    = {1'b0, r_k};
        w_h     = ADDR_W'(1) << w_shift;
        w_grp   = w_kx >> w_shift;
        w_j     = w_kx & (w_h - ADDR_W'(1));
        w_u     = ((w_grp << w_shift) << 1) | w_j;
        w_v     = w_u | w_h;
        w_tw    = (TW_W'(1) << r_stage) + w_grp[TW_W-1:0];
    end

    assign w_issue     = (r_state == S_ISSUE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_stage     = r_stage;
    assign o_rd_en     = w_issue;
    assign o_rd_addr_u = w_issue ? w_u  : '0;
    assign o_rd_addr_v = w_issue ? w_v  : '0;
    assign o_tw_addr   = w_issue ? w_tw : '0;

    ntt_wb_delay #(
        .D  (D),
        .AW (ADDR_W)
    ) u_wb_delay (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (w_issue),
        .i_addr_u (o_rd_addr_u),
        .i_addr_v (o_rd_addr_v),
        .o_valid  (o_wr_en),
        .o_addr_u (o_wr_addr_lower),
        .o_addr_v (o_wr_addr_upper)
    );

endmodule

// File: doc/ntt_pe2_ctrl.md
Name: ntt_pe2_ctrl

Overview:
- Sequences one PE2 butterfly unit through a full in-place forward NTT over a single-port-read/single-port-write coefficient memory.
- Per issue cycle it generates the u/v read addresses and the twiddle ROM address.
- Delays those addresses to match the read-plus-PE2 latency and emits the write-back addresses and enable.
- Sits between the top-level start/done handshake and the coefficient RAM, twiddle ROM and PE2.

Parameters:
- N, 256, polynomial length (power of two).
- LOGN, 8, log2(N).
- NUM_STAGES, 7, butterfly stages executed (7 for degree-2 base case, q = 3329).
- RD_LAT, 1, cycles from rd_en to data valid at PE2 u/v/w2 inputs (RAM and ROM registered).
- PE_LAT, 4, cycles from PE2 inputs to bf_lower/bf_upper valid.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request to begin a transform; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse in the DONE state.
- stage  out  3  current stage index 0..NUM_STAGES-1.
- rd_en  out  1  read strobe for coefficient RAM and twiddle ROM.
- rd_addr_u  out  LOGN  address of operand u.
- rd_addr_v  out  LOGN  address of operand v.
- tw_addr  out  LOGN-1  twiddle ROM address feeding PE2 w2. w1 is tied to the Montgomery-one constant at top level.
- wr_en  out  1  write strobe, aligned with PE2 outputs.
- wr_addr_lower  out  LOGN  destination of bf_lower (sum), equal to the delayed rd_addr_u.
- wr_addr_upper  out  LOGN  destination of bf_upper (difference), equal to the delayed rd_addr_v.

Behaviour:
- Reset:
  - State is IDLE.
  - All outputs are 0, and all counters and the delay line are cleared.
  - Reset asserted mid-transform aborts immediately. No wr_en is produced after reset deassertion until a new start.
- State machine: IDLE -> ISSUE -> DRAIN -> (ISSUE with stage+1, or DONE) -> IDLE.
- IDLE: start=1 moves to ISSUE with stage=0 and k=0. start is ignored in every other state.
- ISSUE:
  - One butterfly per cycle, k = 0..N/2-1. rd_en=1 every ISSUE cycle.
  - Define h = 2^(LOGN-1-stage), grp = k >> (LOGN-1-stage), j = k & (h-1).
  - rd_addr_u = grp*2h + j; rd_addr_v = rd_addr_u + h; tw_addr = 2^stage + grp.
  - All widths are exact; no wrap occurs for the legal parameter range.
  - After k = N/2-1 the block enters DRAIN.
- DRAIN:
  - Lasts exactly D = RD_LAT+PE_LAT cycles with rd_en=0.
  - The final write of the stage lands in the last DRAIN cycle, so the next stage's first read follows it (no RAW hazard, no stall logic).
  - At the end of DRAIN: stage<NUM_STAGES-1 increments stage, resets k and returns to ISSUE; otherwise the block goes to DONE.
- DONE: one cycle, done=1, busy=1, then IDLE.
- Write-back:
  - wr_en and wr_addr_* equal rd_en and rd_addr_u/v delayed by exactly D cycles through a valid+address shift register.
  - wr_en is never asserted in IDLE.
- Total busy cycles = NUM_STAGES*(N/2 + D) + 1. This is 932 at the defaults.
- stage holds its value through DRAIN and resets to 0 in IDLE.

Decomposition:
- Shared package ntt_pkg holds:
  - N, LOGN, NUM_STAGES, Q=3329, DATA_W=12.
  - The state enum {IDLE, ISSUE, DRAIN, DONE}.
  - The address-width constants.
- One sub-module, ntt_wb_delay:
  - Parameterised depth D.
  - Shifts {valid, addr_u, addr_v}.
  - Asynchronous reset clears all valid bits.

Test Plan:
- Reset: assert rst with start=1 -> busy=done=rd_en=wr_en=0 and all addresses 0. After release with start=0, the block stays in IDLE.
- Stage 0, defaults: start -> first ISSUE cycle gives rd_addr_u=0, rd_addr_v=128, tw_addr=1; k=127 gives rd_addr_u=127, rd_addr_v=255, tw_addr=1. wr_en first rises exactly 5 cycles after the first rd_en, with wr_addr_lower=0 and wr_addr_upper=128.
- Stage 6: first ISSUE gives u=0, v=2, tw=64; k=1 gives u=1, v=3, tw=64; k=2 gives u=4, v=6, tw=65; k=127 gives u=253, v=255, tw=127.
- Full run: count cycles -> busy high for exactly 932 cycles, 896 rd_en pulses, 896 wr_en pulses, one done pulse. A software model confirms every address pair is written exactly once per stage.
- start pulses during ISSUE, DRAIN and DONE -> no effect on sequence or cycle count. start in the cycle after DONE -> a new transform begins.
- rst asserted at stage 3, k=40 -> outputs go to 0 asynchronously, no wr_en appears after release, and a subsequent start runs a clean 932-cycle transform.
